resp_serializer: RTL and testbench
==================================

RESP_SERIALIZER -- requirements
Module: resp_serializer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'h55: the first byte of every response frame.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port resp_valid, input, 1: the response FIFO holds a packet and presents it on resp_rd_data (first-word fall-through).
REQ-005 The block SHALL have port resp_rd_data, input, cmd_packet_t: the head response packet; fields opcode[7:0], addr[7:0], data[7:0].
REQ-006 The block SHALL have port resp_rd_en, output, 1: one-cycle pop strobe to the response FIFO.
REQ-007 The block SHALL have port tx_busy, input, 1: uart_tx is transmitting; it rises the cycle after tx_start and falls after the stop bit.
REQ-008 The block SHALL have port tx_start, output, 1: one-cycle strobe that launches tx_data on uart_tx.
REQ-009 The block SHALL have port tx_data, output, 8: the byte to transmit; it is stable from tx_start until tx_busy falls.
REQ-010 The block SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port frame_count, output, 16: the number of frames fully transmitted; it wraps from 16'hFFFF to 0.

Function
REQ-012 Each packet SHALL be sent as a 5-byte frame in this order: SYNC_BYTE, opcode, addr, data, checksum.
REQ-013 The checksum SHALL be opcode XOR addr XOR data, computed on the latched packet.
REQ-014 The FSM SHALL have exactly these states: IDLE, LOAD, SEND, WAIT_HI, WAIT_LO.
- IDLE: if resp_valid=1, assert resp_rd_en for one cycle, latch resp_rd_data, and go to LOAD.
- LOAD: set byte index to 0 and go to SEND.
- SEND: if tx_busy=0, drive tx_data from the indexed byte, pulse tx_start, and go to WAIT_HI; otherwise hold in SEND.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0; if index=4, increment frame_count and return to IDLE; otherwise increment the index and return to SEND.
REQ-015 With tx_busy=0, tx_start for the sync byte SHALL occur exactly 2 cycles after the resp_rd_en cycle.
REQ-016 resp_rd_en SHALL only be asserted in IDLE, never mid-frame, and never for more than one consecutive cycle.
REQ-017 Changes on resp_valid or resp_rd_data after the latch SHALL NOT affect the frame in progress.
REQ-018 If tx_busy is already high on entry to SEND, tx_start SHALL be withheld until tx_busy is low.
REQ-019 Back-to-back frames SHALL be separated by at most 3 idle cycles between the last byte's tx_busy fall and the next resp_rd_en.
REQ-020 The byte index SHALL be 3 bits wide and SHALL never exceed 4.
REQ-021 If resp_valid=0 in IDLE, all strobes SHALL remain low.

Reset
REQ-022 On rst=0, regardless of state, the FSM SHALL enter IDLE immediately and the outputs SHALL be: resp_rd_en=0, tx_start=0, tx_data=8'h00, busy=0, frame_count=0.
REQ-023 A reset mid-frame SHALL abandon the frame without completing it.
REQ-024 After release of rst, no strobe SHALL assert before the first rising clk edge.

Structure
REQ-025 cmd_pkg SHALL hold cmd_packet_t, RESP_SYNC_BYTE (8'h55), and RESP_FRAME_LEN (5).
REQ-026 The block SHALL be a single module with one FSM, a packet latch, an index counter and a frame counter; no sub-module is required.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Single frame: packet {opcode 8'h52, addr 8'h10, data 8'h3C} with tx_busy modelled at 10 cycles/byte -> bytes 55, 52, 10, 3C, 7E in order; frame_count=1.
- Back-to-back: 3 queued packets -> 15 bytes in order, exactly 3 resp_rd_en pulses, and a gap of ≤3 cycles between frames.
- Busy at start: tx_busy held high for 20 cycles after the pop -> no tx_start until tx_busy falls, then the sync byte.
- Reset mid-frame: rst=0 during byte 3 -> strobes low immediately and frame_count=0; after release, the next packet is sent as a complete 5-byte frame.
- Wrap: frame_count forced to 16'hFFFF, then one frame -> frame_count=16'h0000.
- FIFO data change: resp_rd_data altered after the pop -> the frame carries the originally latched values.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types and constants for the command/response path: packet layout,
// response frame constants and the serializer state encoding.
package cmd_pkg;

  localparam int unsigned CMD_BYTE_W     = 8;
  localparam int unsigned RESP_FRAME_LEN = 5;
  localparam int unsigned RESP_IDX_W     = 3;
  localparam int unsigned RESP_CNT_W     = 16;

  localparam logic [CMD_BYTE_W-1:0] RESP_SYNC_BYTE = 8'h55;

  typedef struct packed {
    logic [CMD_BYTE_W-1:0] opcode;
    logic [CMD_BYTE_W-1:0] addr;
    logic [CMD_BYTE_W-1:0] data;
  } cmd_packet_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } resp_state_t;

  // Frame trailer byte: XOR of the three payload fields
  function automatic logic [CMD_BYTE_W-1:0] resp_checksum(input cmd_packet_t p);
    return p.opcode ^ p.addr ^ p.data;
  endfunction

endpackage

// File: rtl/resp_serializer.sv
// Pops response packets from a FWFT FIFO and sends each one to uart_tx as a
// 5-byte frame: sync, opcode, addr, data, checksum.
module resp_serializer
  import cmd_pkg::*;
#(
  parameter logic [CMD_BYTE_W-1:0] SYNC_BYTE = RESP_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  resp_valid,
  input  cmd_packet_t           resp_rd_data,
  output logic                  resp_rd_en,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [CMD_BYTE_W-1:0] tx_data,
  output logic                  busy,
  output logic [RESP_CNT_W-1:0] frame_count
);

  localparam logic [RESP_IDX_W-1:0] LAST_IDX = RESP_IDX_W'(RESP_FRAME_LEN - 1);

  resp_state_t           state, state_nxt;
  cmd_packet_t           pkt, pkt_nxt;
  logic [RESP_IDX_W-1:0] idx, idx_nxt;
  logic                  resp_rd_en_nxt;
  logic                  tx_start_nxt;
  logic [CMD_BYTE_W-1:0] tx_data_nxt;
  logic                  busy_nxt;
  logic [RESP_CNT_W-1:0] frame_count_nxt;
  logic [CMD_BYTE_W-1:0] frame_byte_c;

  // Byte of the latched frame selected by the current index
  always_comb begin
    frame_byte_c = resp_checksum(pkt);
    case (idx)
      3'd0:    frame_byte_c = SYNC_BYTE;
      3'd1:    frame_byte_c = pkt.opcode;
      3'd2:    frame_byte_c = pkt.addr;
      3'd3:    frame_byte_c = pkt.data;
      default: frame_byte_c = resp_checksum(pkt);
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt       = state;
    pkt_nxt         = pkt;
    idx_nxt         = idx;
    resp_rd_en_nxt  = 1'b0;
    tx_start_nxt    = 1'b0;
    tx_data_nxt     = tx_data;
    frame_count_nxt = frame_count;

    case (state)
      IDLE: begin
        if (resp_valid) begin
          resp_rd_en_nxt = 1'b1;
          pkt_nxt        = resp_rd_data;
          state_nxt      = LOAD;
        end
      end
      LOAD: begin
        idx_nxt   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_nxt  = frame_byte_c;
          tx_start_nxt = 1'b1;
          state_nxt    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            frame_count_nxt = frame_count + RESP_CNT_W'(1);
            state_nxt       = IDLE;
          end else begin
            idx_nxt   = idx + RESP_IDX_W'(1);
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pkt         <= '0;
      idx         <= '0;
      resp_rd_en  <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      pkt         <= pkt_nxt;
      idx         <= idx_nxt;
      resp_rd_en  <= resp_rd_en_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
      busy        <= busy_nxt;
      frame_count <= frame_count_nxt;
    end
  end

endmodule

// File: tb/tb_resp_serializer.sv
// Directed bench for resp_serializer: FWFT FIFO and uart_tx models around
// the DUT, with one task per scenario.
module tb_resp_serializer;
  import cmd_pkg::*;

  localparam int BYTE_CYC = 10;
  localparam int BUDGET   = 600;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              resp_valid;
  cmd_packet_t       resp_rd_data;
  logic              resp_rd_en;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;
  logic [15:0]       frame_count;

  int checks = 0;
  int fails  = 0;

  // FIFO model
  cmd_packet_t mem[8];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign resp_valid   = (wr_ptr != rd_ptr);
  assign resp_rd_data = mem[rd_ptr[2:0]];
  always @(posedge clk) if (resp_rd_en) rd_ptr <= rd_ptr + 1;

  // uart_tx model: busy from the cycle after tx_start for BYTE_CYC cycles
  logic mbusy = 1'b0;
  logic hold_busy = 1'b0;
  int   mcnt = 0;
  assign tx_busy = mbusy | hold_busy;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (tx_start) begin
      mbusy <= 1'b1;
      mcnt  <= BYTE_CYC;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mbusy <= 1'b0;
    end
  end

  // Event recorder sampled on the falling edge
  int       cyc = 0;
  int       rd_n = 0;
  int       cap_n = 0;
  int       rd_dup = 0;
  int       start_while_busy = 0;
  int       last_fall = 0;
  logic     prev_busy = 1'b0;
  logic     prev_rd = 1'b0;
  int       rd_cyc[256];
  int       gap[256];
  int       st_cyc[256];
  logic [7:0] cap[256];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_busy <= tx_busy;
    prev_rd   <= resp_rd_en;
    if (prev_busy && !tx_busy) last_fall <= cyc;
    if (resp_rd_en) begin
      rd_cyc[rd_n & 255] <= cyc;
      gap[rd_n & 255]    <= cyc - last_fall - 1;
      rd_n               <= rd_n + 1;
      if (prev_rd) rd_dup <= rd_dup + 1;
    end
    if (tx_start) begin
      cap[cap_n & 255]    <= tx_data;
      st_cyc[cap_n & 255] <= cyc;
      cap_n               <= cap_n + 1;
      if (tx_busy) start_while_busy <= start_while_busy + 1;
    end
  end

  resp_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .resp_valid   (resp_valid),
    .resp_rd_data (resp_rd_data),
    .resp_rd_en   (resp_rd_en),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] op, input logic [7:0] ad, input logic [7:0] da);
    cmd_packet_t p;
    p.opcode = op;
    p.addr   = ad;
    p.data   = da;
    mem[wr_ptr[2:0]] = p;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int target, output bit timed_out);
    int n = 0;
    @(negedge clk);
    while (!(cap_n >= target && !busy && !tx_busy && !resp_valid) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= BUDGET);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_rd_en, tx_start, tx_data, busy, frame_count} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rd_en=%b start=%b data=%h busy=%b fc=%h required all zero",
               resp_rd_en, tx_start, tx_data, busy, frame_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (resp_rd_en !== 1'b0 || tx_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got rd_en=%b start=%b required 0 0", resp_rd_en, tx_start);
    end
  endtask

  task automatic test_idle_no_valid();
    int r0 = rd_n, c0 = cap_n;
    repeat (20) @(negedge clk);
    checks++;
    if (rd_n != r0 || cap_n != c0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_quiet: got pops=%0d starts=%0d busy=%b required 0 0 0", rd_n - r0, cap_n - c0, busy);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_b[5] = '{8'h55, 8'h52, 8'h10, 8'h3C, 8'h7E};
    int r0 = rd_n, c0 = cap_n;
    bit to;
    @(negedge clk);
    push(8'h52, 8'h10, 8'h3C);
    wait_done(c0 + 5, to);
    checks++;
    if (to) begin fails++; $display("FAIL single_timeout: got timeout required frame done"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[c0 + i] !== exp_b[i]) begin
        fails++;
        $display("FAIL single_byte%0d: got %h required %h", i, cap[c0 + i], exp_b[i]);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin fails++; $display("FAIL single_fc: got %0d required 1", frame_count); end
    checks++;
    if (st_cyc[c0] - rd_cyc[r0] != 2) begin
      fails++;
      $display("FAIL single_latency: got %0d required 2", st_cyc[c0] - rd_cyc[r0]);
    end
    checks++;
    if (rd_n - r0 != 1) begin fails++; $display("FAIL single_pops: got %0d required 1", rd_n - r0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[15] = '{8'h55, 8'h01, 8'h02, 8'h04, 8'h07,
                              8'h55, 8'h11, 8'h22, 8'h44, 8'h77,
                              8'h55, 8'h80, 8'h0F, 8'hF0, 8'h7F};
    int r0 = rd_n, c0 = cap_n, d0 = rd_dup;
    bit to;
    @(negedge clk);
    push(8'h01, 8'h02, 8'h04);
    push(8'h11, 8'h22, 8'h44);
    push(8'h80, 8'h0F, 8'hF0);
    wait_done(c0 + 15, to);
    checks++;
    if (to) begin fails++; $display("FAIL b2b_timeout: got timeout required 3 frames done"); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (cap[c0 + i] !== exp_b[i]) begin
        fails++;
        $display("FAIL b2b_byte%0d: got %h required %h", i, cap[c0 + i], exp_b[i]);
      end
    end
    checks++;
    if (rd_n - r0 != 3 || rd_dup != d0) begin
      fails++;
      $display("FAIL b2b_pops: got %0d pops %0d doubled required 3 pops 0 doubled", rd_n - r0, rd_dup - d0);
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (gap[r0 + k] > 3 || gap[r0 + k] < 0) begin
        fails++;
        $display("FAIL b2b_gap%0d: got %0d cycles required 0..3", k, gap[r0 + k]);
      end
    end
    checks++;
    if (frame_count !== 16'd4) begin fails++; $display("FAIL b2b_fc: got %0d required 4", frame_count); end
  endtask

  task automatic test_busy_at_start();
    logic [7:0] exp_b[5] = '{8'h55, 8'h33, 8'h44, 8'h55, 8'h22};
    int r0 = rd_n, c0 = cap_n, s0 = start_while_busy, n = 0, rel;
    bit to;
    @(negedge clk);
    push(8'h33, 8'h44, 8'h55);
    while (rd_n == r0 && n < BUDGET) begin @(negedge clk); n++; end
    hold_busy = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (cap_n != c0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_hold: got starts=%0d busy=%b required 0 1", cap_n - c0, busy);
    end
    rel = cyc;
    hold_busy = 1'b0;
    wait_done(c0 + 5, to);
    checks++;
    if (to) begin fails++; $display("FAIL busy_timeout: got timeout required frame done"); end
    checks++;
    if (st_cyc[c0] < rel || start_while_busy != s0) begin
      fails++;
      $display("FAIL busy_start_order: got start cyc %0d release %0d overlaps %0d", st_cyc[c0], rel, start_while_busy - s0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[c0 + i] !== exp_b[i]) begin
        fails++;
        $display("FAIL busy_byte%0d: got %h required %h", i, cap[c0 + i], exp_b[i]);
      end
    end
  endtask

  task automatic test_data_change();
    logic [7:0] exp_b[5] = '{8'h55, 8'hA1, 8'hB2, 8'hC3, 8'hD0};
    cmd_packet_t junk;
    int r0 = rd_n, c0 = cap_n, n = 0;
    bit to;
    junk = '{opcode: 8'hFF, addr: 8'hFF, data: 8'hFF};
    @(negedge clk);
    push(8'hA1, 8'hB2, 8'hC3);
    while (rd_n == r0 && n < BUDGET) begin @(negedge clk); n++; end
    for (int s = 0; s < 8; s++) mem[s] = junk;
    wait_done(c0 + 5, to);
    checks++;
    if (to) begin fails++; $display("FAIL chg_timeout: got timeout required frame done"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[c0 + i] !== exp_b[i]) begin
        fails++;
        $display("FAIL chg_byte%0d: got %h required %h", i, cap[c0 + i], exp_b[i]);
      end
    end
    checks++;
    if (rd_n - r0 != 1) begin fails++; $display("FAIL chg_pops: got %0d required 1", rd_n - r0); end
  endtask

  task automatic test_wrap();
    int c0 = cap_n;
    bit to;
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    @(negedge clk);
    checks++;
    if (frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preset: got %h required ffff", frame_count); end
    push(8'h0A, 8'h0B, 8'h0C);
    wait_done(c0 + 5, to);
    checks++;
    if (to) begin fails++; $display("FAIL wrap_timeout: got timeout required frame done"); end
    checks++;
    if (cap[c0 + 4] !== 8'h0D) begin fails++; $display("FAIL wrap_cksum: got %h required 0d", cap[c0 + 4]); end
    checks++;
    if (frame_count !== 16'h0000) begin fails++; $display("FAIL wrap_fc: got %h required 0000", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp_b[5] = '{8'h55, 8'h9A, 8'hBC, 8'hDE, 8'hF8};
    int c0 = cap_n, c1, n = 0;
    bit to;
    @(negedge clk);
    push(8'h21, 8'h43, 8'h65);
    while (cap_n < c0 + 3 && n < BUDGET) begin @(negedge clk); n++; end
    checks++;
    if (n >= BUDGET) begin fails++; $display("FAIL rstmid_reach: got timeout required byte 3 reached"); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({resp_rd_en, tx_start, tx_data, busy, frame_count} !== 27'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: got rd_en=%b start=%b data=%h busy=%b fc=%h required all zero",
               resp_rd_en, tx_start, tx_data, busy, frame_count);
    end
    wr_ptr = rd_ptr;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    c1 = cap_n;
    #1;
    checks++;
    if (resp_rd_en !== 1'b0 || tx_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_release: got rd_en=%b start=%b busy=%b required 0 0 0", resp_rd_en, tx_start, busy);
    end
    @(negedge clk);
    push(8'h9A, 8'hBC, 8'hDE);
    wait_done(c1 + 5, to);
    checks++;
    if (to || cap_n - c1 != 5) begin
      fails++;
      $display("FAIL rstmid_frame: got %0d bytes timeout=%b required 5 bytes", cap_n - c1, to);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[c1 + i] !== exp_b[i]) begin
        fails++;
        $display("FAIL rstmid_byte%0d: got %h required %h", i, cap[c1 + i], exp_b[i]);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin fails++; $display("FAIL rstmid_fc: got %0d required 1", frame_count); end
  endtask

  initial begin
    for (int s = 0; s < 8; s++) mem[s] = '0;
    test_reset();
    test_idle_no_valid();
    test_single_frame();
    test_back_to_back();
    test_busy_at_start();
    test_data_change();
    test_wrap();
    test_reset_mid_frame();
    checks++;
    if (rd_dup != 0) begin fails++; $display("FAIL rd_en_double: got %0d doubled pulses required 0", rd_dup); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
